// File: rtl/exc_seq_if.sv
// exc_seq_if: commit-stage / cp0 / fetch signals seen by the interrupt sequencer.
// master: the commit stage, cp0 and fetch side (drives requests, receives strobes).
// slave : the sequencer itself (receives requests, drives strobes and redirects).
`timescale 1ns/1ps
interface exc_seq_if #(
  parameter int CNT_W = 16
) ();
  logic             IntReq;
  logic             inst_valid;
  logic             is_eret;
  logic             is_mtc0;
  logic             busy;
  logic [31:0]      pc;
  logic [31:0]      epc;
  logic [31:0]      epc_pc;
  logic             EpcWr;
  logic             EXLSet;
  logic             EXLClr;
  logic             hold;
  logic             flush;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] int_count;

  modport master (
    output IntReq, inst_valid, is_eret, is_mtc0, busy, pc, epc,
    input  epc_pc, EpcWr, EXLSet, EXLClr, hold, flush, redirect, redirect_pc, int_count
  );

  modport slave (
    input  IntReq, inst_valid, is_eret, is_mtc0, busy, pc, epc,
    output epc_pc, EpcWr, EXLSet, EXLClr, hold, flush, redirect, redirect_pc, int_count
  );
endinterface

// File: rtl/exc_seq.sv
// exc_seq: interrupt entry / eret sequencer between commit and cp0 (sole driver of EpcWr/EXLSet/EXLClr).
// Ports: clk, rst (sync, active-high), bus (exc_seq_if.slave: commit inputs, cp0 strobes, fetch redirect).
// Optional EXC_SEQ_CNT_EN: saturating taken-interrupt counter on int_count; otherwise int_count is 0.
`timescale 1ns/1ps
module exc_seq #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  exc_seq_if.slave   bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DRAIN = 3'd1;
  localparam logic [2:0] SAVE  = 3'd2;
  localparam logic [2:0] JUMP  = 3'd3;
  localparam logic [2:0] RET   = 3'd4;

  logic [2:0]  state;
  logic [2:0]  nxt;
  logic [31:0] epc_l;
  logic        take;

  // An mtc0 may change im/ie, so it wins over IntReq; the request is
  // re-evaluated on the following cycle with the updated cp0 state.
  always_comb begin
    take = 1'b0;
    nxt  = state;
    case (state)
      IDLE: begin
        if (bus.inst_valid && bus.is_mtc0) begin
          nxt = IDLE;
        end else if (bus.IntReq) begin
          take = 1'b1;
          nxt  = bus.busy ? DRAIN : SAVE;
        end else if (bus.inst_valid && bus.is_eret) begin
          nxt = RET;
        end
      end
      // IntReq is deliberately not looked at: an accepted interrupt is always taken.
      DRAIN:   nxt = bus.busy ? DRAIN : SAVE;
      SAVE:    nxt = JUMP;
      JUMP:    nxt = IDLE;
      RET:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      epc_l <= '0;
    end else begin
      state <= nxt;
      // The commit-stage instruction is squashed, so EPC points at it.
      if (take) epc_l <= bus.pc;
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    bus.hold        = 1'b0;
    bus.flush       = 1'b0;
    bus.EpcWr       = 1'b0;
    bus.EXLSet      = 1'b0;
    bus.EXLClr      = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.epc_pc      = epc_l;
    case (state)
      DRAIN: bus.hold = 1'b1;
      SAVE: begin
        bus.hold   = 1'b1;
        bus.flush  = 1'b1;
        bus.EpcWr  = 1'b1;
        bus.EXLSet = 1'b1;
      end
      JUMP: begin
        bus.hold        = 1'b1;
        bus.flush       = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = HANDLER_ADDR;
      end
      RET: begin
        bus.hold        = 1'b1;
        bus.flush       = 1'b1;
        bus.EXLClr      = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = {bus.epc[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  // EPC low bits are dropped: the return target is always word aligned.
  logic unused_epc_lsb;
  assign unused_epc_lsb = &{1'b0, bus.epc[1:0]};

`ifdef EXC_SEQ_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturates instead of wrapping so a long run never reads back as few interrupts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state == SAVE && cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.int_count = cnt_q;
`else
  assign bus.int_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_exc_seq.sv
`timescale 1ns/1ps
module tb_exc_seq;

  localparam int CW = 2;

  localparam int S_IDLE  = 0;
  localparam int S_DRAIN = 1;
  localparam int S_SAVE  = 2;
  localparam int S_JUMP  = 3;
  localparam int S_RET   = 4;

  localparam logic [31:0] EPC_IN = 32'h0000_3013;

  typedef struct packed {
    logic        hold;
    logic        flush;
    logic        epcwr;
    logic        exlset;
    logic        exlclr;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] epc_pc;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  exc_seq_if #(.CNT_W(CW)) bus ();

  exc_seq #(.HANDLER_ADDR(32'h0000_4180), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, push the expected outputs of the state that
  // the coming edge should enter, then pop and compare after the edge.
  task automatic step(input logic r, input logic ir, input logic iv, input logic er,
                      input logic mt, input logic bz, input logic [31:0] p,
                      input int st, input logic [31:0] xepc);
    exp_t x;
    exp_t g;
    rst            = r;
    bus.IntReq     = ir;
    bus.inst_valid = iv;
    bus.is_eret    = er;
    bus.is_mtc0    = mt;
    bus.busy       = bz;
    bus.pc         = p;
    bus.epc        = EPC_IN;

    x = '0;
    x.epc_pc = xepc;
    case (st)
      S_DRAIN: x.hold = 1'b1;
      S_SAVE:  begin x.hold = 1'b1; x.flush = 1'b1; x.epcwr = 1'b1; x.exlset = 1'b1; end
      S_JUMP:  begin x.hold = 1'b1; x.flush = 1'b1; x.redirect = 1'b1; x.rpc = 32'h0000_4180; end
      S_RET:   begin x.hold = 1'b1; x.flush = 1'b1; x.exlclr = 1'b1; x.redirect = 1'b1;
                     x.rpc = 32'h0000_3010; end
      default: ;
    endcase
    if (r) exp_cnt = 0;
`ifdef EXC_SEQ_CNT_EN
    x.cnt = exp_cnt;
`else
    x.cnt = 0;
`endif
    if (st == S_SAVE && exp_cnt < (1 << CW) - 1) exp_cnt++;
    sb.push_back(x);

    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed 0 expected 1");
    end
    if (sb.size() != 0) begin
      g = sb.pop_front();
      chk("hold",        {31'b0, bus.hold},     {31'b0, g.hold});
      chk("flush",       {31'b0, bus.flush},    {31'b0, g.flush});
      chk("EpcWr",       {31'b0, bus.EpcWr},    {31'b0, g.epcwr});
      chk("EXLSet",      {31'b0, bus.EXLSet},   {31'b0, g.exlset});
      chk("EXLClr",      {31'b0, bus.EXLClr},   {31'b0, g.exlclr});
      chk("redirect",    {31'b0, bus.redirect}, {31'b0, g.redirect});
      chk("redirect_pc", bus.redirect_pc,       g.rpc);
      chk("epc_pc",      bus.epc_pc,            g.epc_pc);
      chk("int_count",   {{(32-CW){1'b0}}, bus.int_count}, g.cnt);
    end
  endtask

  initial begin
    // Reset and quiet idle
    step(1, 0, 0, 0, 0, 0, 32'h0000_2000, S_IDLE, 32'h0);
    step(1, 1, 1, 1, 0, 1, 32'h0000_2004, S_IDLE, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0000_2008, S_IDLE, 32'h0);

    // Idle interrupt, no drain
    step(0, 1, 0, 0, 0, 0, 32'h0000_3010, S_SAVE, 32'h0000_3010);
    step(0, 0, 0, 0, 0, 0, 32'h0000_3014, S_JUMP, 32'h0000_3010);
    step(0, 0, 0, 0, 0, 0, 32'h0000_3018, S_IDLE, 32'h0000_3010);

    // Drain: busy held 5 edges, IntReq/pc changes during DRAIN ignored
    step(0, 1, 0, 0, 0, 1, 32'h0000_3020, S_DRAIN, 32'h0000_3020);
    step(0, 0, 0, 0, 0, 1, 32'h0000_3024, S_DRAIN, 32'h0000_3020);
    step(0, 1, 0, 0, 0, 1, 32'h0000_3028, S_DRAIN, 32'h0000_3020);
    step(0, 0, 1, 1, 0, 1, 32'h0000_302c, S_DRAIN, 32'h0000_3020);
    step(0, 1, 0, 0, 0, 1, 32'h0000_3030, S_DRAIN, 32'h0000_3020);
    step(0, 0, 0, 0, 0, 0, 32'h0000_3034, S_SAVE,  32'h0000_3020);
    // IntReq while in SAVE is ignored
    step(0, 1, 0, 0, 0, 0, 32'h0000_3038, S_JUMP,  32'h0000_3020);
    step(0, 0, 0, 0, 0, 0, 32'h0000_303c, S_IDLE,  32'h0000_3020);

    // eret
    step(0, 0, 1, 1, 0, 0, 32'h0000_3040, S_RET,  32'h0000_3020);
    step(0, 0, 0, 0, 0, 0, 32'h0000_3044, S_IDLE, 32'h0000_3020);
    // eret not qualified by inst_valid
    step(0, 0, 0, 1, 0, 0, 32'h0000_3048, S_IDLE, 32'h0000_3020);

    // mtc0 collides with IntReq, then IntReq still high
    step(0, 1, 1, 0, 1, 0, 32'h0000_3050, S_IDLE, 32'h0000_3020);
    step(0, 1, 0, 0, 0, 0, 32'h0000_3054, S_SAVE, 32'h0000_3054);
    step(0, 0, 0, 0, 0, 0, 32'h0000_3058, S_JUMP, 32'h0000_3054);
    step(0, 0, 0, 0, 0, 0, 32'h0000_305c, S_IDLE, 32'h0000_3054);

    // IntReq outranks eret in the same cycle
    step(0, 1, 1, 1, 0, 0, 32'h0000_3060, S_SAVE, 32'h0000_3060);
    step(0, 0, 0, 0, 0, 0, 32'h0000_3064, S_JUMP, 32'h0000_3060);
    step(0, 0, 0, 0, 0, 0, 32'h0000_3068, S_IDLE, 32'h0000_3060);

    // Reset while in DRAIN: no SAVE afterwards
    step(0, 1, 0, 0, 0, 1, 32'h0000_3070, S_DRAIN, 32'h0000_3070);
    step(1, 0, 0, 0, 0, 1, 32'h0000_3074, S_IDLE,  32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0000_3078, S_IDLE,  32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0000_307c, S_IDLE,  32'h0);

    // Reset while in SAVE: JUMP never happens
    step(0, 1, 0, 0, 0, 0, 32'h0000_3080, S_SAVE, 32'h0000_3080);
    step(1, 0, 0, 0, 0, 0, 32'h0000_3084, S_IDLE, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0000_3088, S_IDLE, 32'h0);

    // Five interrupts: counter (when built in) saturates at 3
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 0, 32'h0000_3100 + 32'(i * 16), S_SAVE, 32'h0000_3100 + 32'(i * 16));
      step(0, 0, 0, 0, 0, 0, 32'h0000_3104 + 32'(i * 16), S_JUMP, 32'h0000_3100 + 32'(i * 16));
      step(0, 0, 0, 0, 0, 0, 32'h0000_3108 + 32'(i * 16), S_IDLE, 32'h0000_3100 + 32'(i * 16));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_seq.md
# exc_seq

Interrupt entry/return sequencer for the multi-cycle MIPS CPU. It sits between the commit stage and `cp0`. It samples `IntReq`, drains any busy multi-cycle unit, then drives `cp0`'s `EpcWr`/`EXLSet` to save the interrupted PC and redirects fetch to the handler. On `eret` it drives `EXLClr` and redirects fetch to EPC. It is the only block allowed to drive `cp0`'s `EXLSet`, `EXLClr` and `EpcWr`.

## Interface
Parameters:
- `HANDLER_ADDR`, default `32'h0000_4180`: handler entry address.
- `CNT_W`, default `16`: width of the taken-interrupt counter (used only with `EXC_SEQ_CNT_EN`).

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `IntReq` in 1: interrupt request from `cp0`.
- `inst_valid` in 1: the commit-stage instruction is valid this cycle.
- `is_eret` in 1: the commit-stage instruction is `eret`; qualified by `inst_valid`.
- `is_mtc0` in 1: the commit-stage instruction is `mtc0`; qualified by `inst_valid`.
- `busy` in 1: multiply/divide unit busy.
- `pc` in 32: commit-stage PC.
- `epc` in 32: EPC value from `cp0`.
- `epc_pc` out 32: PC value presented to `cp0`'s `pc` input.
- `EpcWr` out 1: EPC write strobe to `cp0`.
- `EXLSet` out 1: set EXL in `cp0`.
- `EXLClr` out 1: clear EXL in `cp0`.
- `hold` out 1: freezes fetch/decode and blocks commit; also forces `cp0` `Wen` low.
- `flush` out 1: squashes all uncommitted instructions.
- `redirect` out 1: load `redirect_pc` into the fetch PC.
- `redirect_pc` out 32: fetch redirect target.
- `int_count` out `CNT_W`: number of interrupts taken (only with `EXC_SEQ_CNT_EN`).

## Operation
The FSM has five states: `IDLE`, `DRAIN`, `SAVE`, `JUMP`, `RET`. All outputs are Moore outputs decoded from the state register plus a registered PC latch `epc_l`.

`IDLE`: all strobes are 0 and `epc_pc = epc_l`. Transitions in priority order:
- `inst_valid & is_mtc0` → stay in `IDLE`. The `mtc0` commits, and `IntReq` is re-evaluated next cycle because the `mtc0` may change `im`/`ie`.
- `IntReq & busy` → `DRAIN`; latch `epc_l <= pc`.
- `IntReq & !busy` → `SAVE`; latch `epc_l <= pc`. The commit-stage instruction is squashed, not committed, so EPC points at it.
- `inst_valid & is_eret` → `RET`. Because EXL=1 inside a handler, `IntReq` is 0 there.

`DRAIN`: `hold=1`. Goes to `SAVE` when `busy=0`; otherwise stays. `IntReq` is not re-sampled here: once accepted, an interrupt is always taken.

`SAVE`: `hold=1`, `flush=1`, `EpcWr=1`, `EXLSet=1`, `epc_pc=epc_l`. Always goes to `JUMP`.

`JUMP`: `hold=1`, `flush=1`, `redirect=1`, `redirect_pc=HANDLER_ADDR`. Always goes to `IDLE`.

`RET`: `hold=1`, `flush=1`, `EXLClr=1`, `redirect=1`, `redirect_pc={epc[31:2],2'b00}`. Always goes to `IDLE`.

Invariants:
- `EXLSet` and `EXLClr` are never 1 in the same cycle.
- `EpcWr` is asserted only in `SAVE`.
- `hold` is 1 in every non-`IDLE` state, so `cp0` never sees `Wen=1` together with `EXLSet`/`EpcWr`.

## Timing
- Reset (sync, `rst=1` at an edge) → state `IDLE`, `epc_l=0`, `int_count=0`. All outputs are 0 the cycle after, including `redirect_pc=0` and `epc_pc=0`.
- Reset mid-sequence (`DRAIN`/`SAVE`/`JUMP`/`RET`): `IDLE` next cycle. No further strobes; a partial `SAVE` is not completed.
- Interrupt latency with no drain: `IntReq` sampled at edge N → `SAVE` in cycle N+1 → `JUMP` in N+2 → `IDLE` in N+3. The handler's first fetch is in cycle N+3.
- With drain: `SAVE` occurs in the first cycle after the cycle in which `busy` is sampled 0.
- `eret` latency: `RET` in cycle N+1, `IDLE` in N+2. `EXLClr` takes effect in `cp0` at the end of N+1, so a pending interrupt can be accepted from N+2.
- `IntReq` pulses that occur outside `IDLE` are ignored. Re-assertion is the responsibility of `cp0` via `ip`.

## Configuration
- `EXC_SEQ_CNT_EN` defined: `int_count` increments by 1 on every `SAVE` cycle and saturates at all-ones (no wrap). It is cleared by `rst`.
- `EXC_SEQ_CNT_EN` undefined: no counter register; `int_count` is tied to 0.

## Test plan
- Idle interrupt: `pc=32'h0000_3010`, `busy=0`, `IntReq` pulsed 1 cycle → next cycle `EpcWr=1`, `EXLSet=1`, `epc_pc=32'h0000_3010`; the following cycle `redirect=1`, `redirect_pc=32'h0000_4180`.
- Drain: `IntReq=1` with `busy=1` held 5 cycles → `hold=1` and `EpcWr=0` for 5 cycles; `SAVE` occurs the cycle after `busy` falls.
- Return: `epc=32'h0000_3013`, `inst_valid=1`, `is_eret=1` → next cycle `EXLClr=1`, `redirect_pc=32'h0000_3010`, `EXLSet=0`.
- `mtc0` collision: `is_mtc0=1` and `IntReq=1` in the same cycle → no `SAVE` that cycle. If `IntReq` is still 1 the next cycle → `SAVE` one cycle later.
- Reset mid-sequence: `rst=1` while in `DRAIN` → all outputs 0 next cycle and no `EpcWr` pulse afterwards; with `EXC_SEQ_CNT_EN`, `int_count=0`.
- Counter: with `EXC_SEQ_CNT_EN` and `CNT_W=2`, take 5 interrupts → `int_count` reads 1, 2, 3, 3, 3.
